uartm_frame_dec: RTL and testbench
==================================

Name: uartm_frame_dec

Overview:
- Byte-level command decoder between the UART receive deserialiser and the AHB master sequencer of the UART debug master.
- Consumes received bytes, recognises read/write preambles, and assembles a little-endian 32-bit address and optional 32-bit write data.
- Presents one complete command per frame on a valid/ready interface.
- Aborts partial frames on an inter-byte timeout, and reports malformed or overrun traffic as error pulses.

Parameters:
- RD_PREAMBLE, 8'h4D, first byte of a read frame.
- WR_PREAMBLE, 8'h34, first byte of a write frame.
- TO_W, 32, width of the timeout counter and of the timeout_cyc port.

Ports:
- hclk  in  1  clock.
- hreset  in  1  synchronous active-high reset.
- rx_byte_vld  in  1  single-cycle strobe: rx_byte holds a new received byte.
- rx_byte  in  8  received byte.
- timeout_cyc  in  TO_W  inter-byte timeout in hclk cycles; 0 disables the timeout.
- cmd_vld  out  1  complete command available.
- cmd_rdy  in  1  AHB sequencer accepts the command.
- cmd_write  out  1  1 = write, 0 = read.
- cmd_addr  out  32  assembled address.
- cmd_wdata  out  32  assembled write data; 0 for reads.
- busy  out  1  frame in progress (state other than IDLE).
- err_preamble  out  1  1-cycle pulse: unknown byte received in IDLE.
- err_timeout  out  1  1-cycle pulse: partial frame aborted.
- err_overrun  out  1  1-cycle pulse: byte dropped while a command is pending.

Behaviour:
- Reset is synchronous, so it applies on the hclk edge where hreset=1.
  - state=IDLE; byte counter=0; timeout counter=0.
  - All outputs are 0, including cmd_addr and cmd_wdata.
  - Reset mid-frame discards the partial frame without raising any error pulse.
- FSM states: IDLE, ADDR, DATA, CMD.
- IDLE, on rx_byte_vld:
  - RD_PREAMBLE: go to ADDR; cmd_write<=0; cmd_wdata<=0.
  - WR_PREAMBLE: go to ADDR; cmd_write<=1.
  - Any other value: stay in IDLE; err_preamble=1 on the next cycle.
- ADDR:
  - Byte k (k=0..3) is written to cmd_addr[8k+7:8k], so byte 0 is the LSB.
  - After byte 3: a read goes to CMD; a write goes to DATA with the byte counter cleared.
- DATA:
  - Byte k is written to cmd_wdata[8k+7:8k].
  - After byte 3, go to CMD.
- CMD:
  - cmd_vld=1 on the cycle after the last byte is captured.
  - cmd_write, cmd_addr and cmd_wdata are stable while cmd_vld=1.
  - Handshake completes on an edge where cmd_vld & cmd_rdy; state goes to IDLE and cmd_vld=0 on the next cycle.
  - cmd_vld is never withdrawn before the handshake.
  - A byte arriving on the handshake cycle is processed as if in IDLE (it may start the next frame or raise err_preamble).
  - A byte arriving in CMD without cmd_rdy is dropped; err_overrun pulses on the next cycle.
- Timeout (ADDR and DATA only):
  - The counter clears on entry to ADDR and on every accepted byte, and increments on every other cycle.
  - Abort condition: timeout_cyc!=0, counter==timeout_cyc, and no byte on that cycle. On abort, go to IDLE and pulse err_timeout on the next cycle.
  - A byte arriving on the expiry cycle wins: it is accepted and the counter clears.
  - timeout_cyc=0 means frames never time out.
  - The counter does not run in IDLE or CMD.
- After an abort, cmd_addr and cmd_wdata keep their partial contents; cmd_vld stays 0.
- Latency: cmd_vld rises exactly 1 cycle after the final byte strobe (5th byte of a read frame, 9th of a write frame).
- busy=1 in ADDR, DATA and CMD.
- At most one error pulse fires per cycle; the error conditions are mutually exclusive by state.

Test Plan:
1. Read frame: bytes 4D,78,56,34,12 with cmd_rdy=1 -> cmd_vld one cycle after byte 12, cmd_write=0, cmd_addr=32'h12345678, cmd_wdata=0; cmd_vld=0 on the following cycle.
2. Write frame: bytes 34,00,10,00,40,EF,BE,AD,DE, with cmd_rdy held 0 for 5 cycles then 1 -> cmd_write=1, cmd_addr=32'h40001000, cmd_wdata=32'hDEADBEEF; cmd_vld is held for 6 cycles, then IDLE.
3. Timeout: timeout_cyc=10; bytes 4D,01 then silence -> err_timeout pulses after 10 idle cycles, busy=0, no cmd_vld.
   - Repeat with a byte on exactly the 10th idle cycle -> no abort.
   - Repeat with timeout_cyc=0 -> never aborts.
4. Bad preamble: byte A5 in IDLE -> err_preamble for 1 cycle, state stays IDLE; a following valid read frame decodes correctly.
5. Overrun and back-to-back:
   - In CMD with cmd_rdy=0, byte 4D -> err_overrun, byte dropped.
   - Byte 4D coincident with the cmd_rdy handshake -> next frame starts in ADDR.
6. Reset mid-frame: hreset=1 after 2 address bytes of a write -> all outputs 0 next cycle, no error pulse; a subsequent full read frame decodes correctly.

Source files
------------

// File: rtl/uartm_frame_dec_if.sv
// Byte-in / command-out bundle between the UART deserialiser, the frame decoder
// and the AHB master sequencer.
interface uartm_frame_dec_if #(parameter int TO_W = 32);
  logic            rx_byte_vld;
  logic [7:0]      rx_byte;
  logic [TO_W-1:0] timeout_cyc;
  logic            cmd_vld;
  logic            cmd_rdy;
  logic            cmd_write;
  logic [31:0]     cmd_addr;
  logic [31:0]     cmd_wdata;
  logic            busy;
  logic            err_preamble;
  logic            err_timeout;
  logic            err_overrun;

  modport master (
    input  rx_byte_vld, rx_byte, timeout_cyc, cmd_rdy,
    output cmd_vld, cmd_write, cmd_addr, cmd_wdata, busy,
           err_preamble, err_timeout, err_overrun
  );

  modport slave (
    output rx_byte_vld, rx_byte, timeout_cyc, cmd_rdy,
    input  cmd_vld, cmd_write, cmd_addr, cmd_wdata, busy,
           err_preamble, err_timeout, err_overrun
  );
endinterface

// File: rtl/uartm_frame_dec.sv
// UART debug-master frame decoder: preamble + LE 32-bit address (+ LE 32-bit wdata)
// assembled into one valid/ready command, with inter-byte timeout and error pulses.
module uartm_frame_dec #(
  parameter logic [7:0] RD_PREAMBLE = 8'h4D,
  parameter logic [7:0] WR_PREAMBLE = 8'h34,
  parameter int         TO_W        = 32
) (
  input logic              hclk,
  input logic              hreset,
  uartm_frame_dec_if.master bus
);
  typedef enum logic [1:0] {IDLE, ADDR, DATA, CMD} state_e;

  localparam logic [TO_W-1:0] TO_ONE = {{(TO_W-1){1'b0}}, 1'b1};

  state_e          state_q, state_d;
  logic [1:0]      cnt_q, cnt_d;
  logic [TO_W-1:0] to_q, to_d;
  logic            write_q, write_d;
  logic [31:0]     addr_q, addr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic            epre_q, epre_d;
  logic            eto_q, eto_d;
  logic            eovr_q, eovr_d;
  logic            take_idle;
  logic            expire;

  assign expire = (bus.timeout_cyc != '0) && (to_q == bus.timeout_cyc);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    to_d      = to_q;
    write_d   = write_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    epre_d    = 1'b0;
    eto_d     = 1'b0;
    eovr_d    = 1'b0;
    take_idle = 1'b0;
    case (state_q)
      IDLE: take_idle = bus.rx_byte_vld;
      ADDR, DATA: begin
        if (bus.rx_byte_vld) begin
          if (state_q == ADDR) addr_d[{cnt_q, 3'b000} +: 8]  = bus.rx_byte;
          else                 wdata_d[{cnt_q, 3'b000} +: 8] = bus.rx_byte;
          cnt_d = cnt_q + 2'd1;
          to_d  = '0;
          // cnt wraps to 0 after byte 3, which also clears it for the data phase
          if (cnt_q == 2'd3)
            state_d = (state_q == ADDR && write_q) ? DATA : CMD;
        end else if (expire) begin
          state_d = IDLE;
          eto_d   = 1'b1;
        end else begin
          to_d = to_q + TO_ONE;
        end
      end
      CMD: begin
        if (bus.cmd_rdy) begin
          state_d   = IDLE;
          take_idle = bus.rx_byte_vld;
        end else if (bus.rx_byte_vld) begin
          eovr_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (take_idle) begin
      if (bus.rx_byte == RD_PREAMBLE) begin
        state_d = ADDR;
        write_d = 1'b0;
        wdata_d = '0;
        cnt_d   = '0;
        to_d    = '0;
      end else if (bus.rx_byte == WR_PREAMBLE) begin
        state_d = ADDR;
        write_d = 1'b1;
        cnt_d   = '0;
        to_d    = '0;
      end else begin
        epre_d = 1'b1;
      end
    end
  end

  always_ff @(posedge hclk) begin
    if (hreset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      to_q    <= '0;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      epre_q  <= 1'b0;
      eto_q   <= 1'b0;
      eovr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      to_q    <= to_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      epre_q  <= epre_d;
      eto_q   <= eto_d;
      eovr_q  <= eovr_d;
    end
  end

  assign bus.cmd_vld      = (state_q == CMD);
  assign bus.cmd_write    = write_q;
  assign bus.cmd_addr     = addr_q;
  assign bus.cmd_wdata    = wdata_q;
  assign bus.busy         = (state_q != IDLE);
  assign bus.err_preamble = epre_q;
  assign bus.err_timeout  = eto_q;
  assign bus.err_overrun  = eovr_q;
endmodule

// File: tb/tb_uartm_frame_dec.sv
// Directed bench for uartm_frame_dec: read/write frames, timeout boundary,
// bad preamble, overrun, back-to-back handshake and mid-frame reset.
module tb_uartm_frame_dec;
  logic hclk = 1'b0;
  logic hreset;
  int   checks = 0;
  int   failures = 0;

  uartm_frame_dec_if #(.TO_W(32)) bus ();

  uartm_frame_dec dut (.hclk(hclk), .hreset(hreset), .bus(bus));

  always #5 hclk = ~hclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge hclk);
      #1;
    end
  endtask

  task automatic send(input logic [7:0] b);
    bus.rx_byte_vld = 1'b1;
    bus.rx_byte     = b;
    cyc(1);
    bus.rx_byte_vld = 1'b0;
    bus.rx_byte     = 8'h00;
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_vld"},   {31'd0, bus.cmd_vld},   32'd0);
    chk({tag, "_wr"},    {31'd0, bus.cmd_write}, 32'd0);
    chk({tag, "_addr"},  bus.cmd_addr,           32'd0);
    chk({tag, "_wdata"}, bus.cmd_wdata,          32'd0);
    chk({tag, "_busy"},  {31'd0, bus.busy},      32'd0);
    chk({tag, "_errs"},  {29'd0, bus.err_preamble, bus.err_timeout, bus.err_overrun}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.rx_byte_vld = 1'b0;
    bus.rx_byte     = 8'h00;
    bus.timeout_cyc = 32'd0;
    bus.cmd_rdy     = 1'b0;
    hreset          = 1'b1;
    cyc(3);
    chk_outputs_zero("reset");
    hreset = 1'b0;
    cyc(1);

    // 1: read frame, sequencer ready
    bus.cmd_rdy = 1'b1;
    send(8'h4D); send(8'h78); send(8'h56); send(8'h34);
    chk("t1_vld_before_last", {31'd0, bus.cmd_vld}, 32'd0);
    send(8'h12);
    chk("t1_vld",   {31'd0, bus.cmd_vld},   32'd1);
    chk("t1_wr",    {31'd0, bus.cmd_write}, 32'd0);
    chk("t1_addr",  bus.cmd_addr,           32'h12345678);
    chk("t1_wdata", bus.cmd_wdata,          32'd0);
    cyc(1);
    chk("t1_vld_drop", {31'd0, bus.cmd_vld}, 32'd0);
    chk("t1_busy",     {31'd0, bus.busy},    32'd0);

    // 2: write frame, ready held low for 5 cycles
    bus.cmd_rdy = 1'b0;
    send(8'h34); send(8'h00); send(8'h10); send(8'h00); send(8'h40);
    chk("t2_busy_data", {31'd0, bus.busy},    32'd1);
    chk("t2_vld_data",  {31'd0, bus.cmd_vld}, 32'd0);
    send(8'hEF); send(8'hBE); send(8'hAD); send(8'hDE);
    chk("t2_vld",   {31'd0, bus.cmd_vld},   32'd1);
    chk("t2_wr",    {31'd0, bus.cmd_write}, 32'd1);
    chk("t2_addr",  bus.cmd_addr,           32'h40001000);
    chk("t2_wdata", bus.cmd_wdata,          32'hDEADBEEF);
    cyc(5);
    chk("t2_vld_held",   {31'd0, bus.cmd_vld}, 32'd1);
    chk("t2_wdata_held", bus.cmd_wdata,        32'hDEADBEEF);
    bus.cmd_rdy = 1'b1;
    cyc(1);
    chk("t2_vld_drop", {31'd0, bus.cmd_vld}, 32'd0);
    chk("t2_busy",     {31'd0, bus.busy},    32'd0);

    // 3a: timeout abort; counter reaches 10 after 10 silent cycles, aborts on the 11th
    bus.timeout_cyc = 32'd10;
    send(8'h4D); send(8'h01);
    cyc(10);
    chk("t3a_busy_pre", {31'd0, bus.busy},        32'd1);
    chk("t3a_eto_pre",  {31'd0, bus.err_timeout}, 32'd0);
    cyc(1);
    chk("t3a_eto",  {31'd0, bus.err_timeout}, 32'd1);
    chk("t3a_busy", {31'd0, bus.busy},        32'd0);
    chk("t3a_vld",  {31'd0, bus.cmd_vld},     32'd0);
    chk("t3a_addr_partial", {24'd0, bus.cmd_addr[7:0]}, 32'h01);
    cyc(1);
    chk("t3a_eto_pulse", {31'd0, bus.err_timeout}, 32'd0);

    // 3b: byte on the expiry cycle wins
    send(8'h4D); send(8'h01);
    cyc(10);
    send(8'h02);
    chk("t3b_eto",  {31'd0, bus.err_timeout}, 32'd0);
    chk("t3b_busy", {31'd0, bus.busy},        32'd1);
    cyc(10);
    chk("t3b_busy_restart", {31'd0, bus.busy}, 32'd1);
    send(8'h03); send(8'h04);
    chk("t3b_vld",   {31'd0, bus.cmd_vld}, 32'd1);
    chk("t3b_addr",  bus.cmd_addr,         32'h04030201);
    chk("t3b_wdata", bus.cmd_wdata,        32'd0);
    cyc(1);

    // 3c: timeout disabled
    bus.timeout_cyc = 32'd0;
    send(8'h4D); send(8'h0A);
    cyc(40);
    chk("t3c_busy", {31'd0, bus.busy},        32'd1);
    chk("t3c_eto",  {31'd0, bus.err_timeout}, 32'd0);
    send(8'h0B); send(8'h0C); send(8'h0D);
    chk("t3c_vld",  {31'd0, bus.cmd_vld}, 32'd1);
    chk("t3c_addr", bus.cmd_addr,         32'h0D0C0B0A);
    cyc(1);

    // 4: bad preamble then a good read
    send(8'hA5);
    chk("t4_epre", {31'd0, bus.err_preamble}, 32'd1);
    chk("t4_busy", {31'd0, bus.busy},         32'd0);
    cyc(1);
    chk("t4_epre_pulse", {31'd0, bus.err_preamble}, 32'd0);
    send(8'h4D); send(8'hEF); send(8'hBE); send(8'hAD); send(8'hDE);
    chk("t4_vld",  {31'd0, bus.cmd_vld},   32'd1);
    chk("t4_wr",   {31'd0, bus.cmd_write}, 32'd0);
    chk("t4_addr", bus.cmd_addr,           32'hDEADBEEF);
    cyc(1);

    // 5: overrun while pending, then preamble on the handshake cycle
    bus.cmd_rdy = 1'b0;
    send(8'h4D); send(8'h11); send(8'h22); send(8'h33); send(8'h44);
    chk("t5_vld", {31'd0, bus.cmd_vld}, 32'd1);
    send(8'h4D);
    chk("t5_eovr",      {31'd0, bus.err_overrun}, 32'd1);
    chk("t5_vld_kept",  {31'd0, bus.cmd_vld},     32'd1);
    chk("t5_addr_kept", bus.cmd_addr,             32'h44332211);
    cyc(1);
    chk("t5_eovr_pulse", {31'd0, bus.err_overrun}, 32'd0);
    bus.cmd_rdy = 1'b1;
    send(8'h4D);
    chk("t5_b2b_vld",  {31'd0, bus.cmd_vld},      32'd0);
    chk("t5_b2b_busy", {31'd0, bus.busy},         32'd1);
    chk("t5_b2b_epre", {31'd0, bus.err_preamble}, 32'd0);
    send(8'h01); send(8'h02); send(8'h03); send(8'h04);
    chk("t5_b2b_vld2", {31'd0, bus.cmd_vld}, 32'd1);
    chk("t5_b2b_addr", bus.cmd_addr,         32'h04030201);
    cyc(1);

    // 6: reset in the middle of a write frame
    send(8'h34); send(8'hAA); send(8'hBB);
    chk("t6_busy_pre", {31'd0, bus.busy}, 32'd1);
    hreset = 1'b1;
    cyc(1);
    hreset = 1'b0;
    chk_outputs_zero("t6_reset");
    cyc(3);
    chk("t6_errs_after", {29'd0, bus.err_preamble, bus.err_timeout, bus.err_overrun}, 32'd0);
    send(8'h4D); send(8'h78); send(8'h56); send(8'h34); send(8'h12);
    chk("t6_vld",  {31'd0, bus.cmd_vld},   32'd1);
    chk("t6_wr",   {31'd0, bus.cmd_write}, 32'd0);
    chk("t6_addr", bus.cmd_addr,           32'h12345678);
    cyc(1);
    chk("t6_idle", {31'd0, bus.busy}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
